// File: rtl/imem_load_run_controller_if.sv
// rtl/imem_load_run_controller_if.sv - byte-in, program-memory-write and fetch handshake bundle
//
// Signals:
//   i_rx_valid, i_rx_byte        UART receiver byte strobe and data
//   i_data_ready, i_id_ack       fetch IF/ID occupied, decoder consumed instruction
//   o_write_enable               program memory write enable
//   o_load_address               program memory write address (ADDR_W bits)
//   o_load_instruction           program memory write data (32 bits)
//   o_flush                      flush request to fetch stage
// Modports: master = controller, slave = surrounding pipeline/receiver.
interface imem_load_run_controller_if #(
    parameter int ADDR_W = 3
);
    logic              i_rx_valid;
    logic [7:0]        i_rx_byte;
    logic              i_data_ready;
    logic              i_id_ack;
    logic              o_write_enable;
    logic [ADDR_W-1:0] o_load_address;
    logic [31:0]       o_load_instruction;
    logic              o_flush;

    modport master (
        input  i_rx_valid, i_rx_byte, i_data_ready, i_id_ack,
        output o_write_enable, o_load_address, o_load_instruction, o_flush
    );

    modport slave (
        output i_rx_valid, i_rx_byte, i_data_ready, i_id_ack,
        input  o_write_enable, o_load_address, o_load_instruction, o_flush
    );
endinterface

// File: rtl/imem_load_run_controller.sv
// rtl/imem_load_run_controller.sv - packs UART bytes into program memory, then sequences fetch flushes
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   bus             imem_load_run_controller_if.master (byte input, memory write port, flush handshake)
//   i_start         begin run (needs at least one loaded word)
//   i_clear         leave DONE and clear counts
//   o_busy          high outside IDLE and DONE
//   o_done          high in DONE
//   o_overrun       sticky dropped-byte flag
//   o_loaded_count  words written, 0..DEPTH
module imem_load_run_controller #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int WE_HIGH   = 2,
    parameter int WE_LOW    = 4,
    parameter int FLUSH_LEN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    imem_load_run_controller_if.master    bus,
    input  logic                          i_start,
    input  logic                          i_clear,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overrun,
    output logic [ADDR_W:0]               o_loaded_count
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]  WE_HIGH_LAST   = CNT_W'(WE_HIGH - 1);
    localparam logic [CNT_W-1:0]  WE_LOW_LAST    = CNT_W'(WE_LOW - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST     = CNT_W'(FLUSH_LEN - 1);
    localparam logic [ADDR_W:0]   LAST_BEFORE_FULL = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, ASSEMBLE, WRITE_HI, WRITE_LO, FULL, RUN, FLUSH, WAIT_CLR, DONE
    } state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [23:0]       partial;      // bytes 0..2 of the word being assembled
    logic [CNT_W-1:0]  cnt;          // shared phase timer for write and flush pulses
    logic [ADDR_W:0]   retired;
    logic              write_enable;
    logic              flush;
    logic [ADDR_W-1:0] load_address;
    logic [31:0]       load_instruction;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [ADDR_W:0]   loaded_count;

    assign bus.o_write_enable     = write_enable;
    assign bus.o_load_address     = load_address;
    assign bus.o_load_instruction = load_instruction;
    assign bus.o_flush            = flush;
    assign o_busy                 = busy;
    assign o_done                 = done;
    assign o_overrun              = overrun;
    assign o_loaded_count         = loaded_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            byte_idx         <= '0;
            partial          <= '0;
            cnt              <= '0;
            retired          <= '0;
            write_enable     <= 1'b0;
            flush            <= 1'b0;
            load_address     <= '0;
            load_instruction <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            overrun          <= 1'b0;
            loaded_count     <= '0;
        end else begin
            // Only IDLE and ASSEMBLE can accept a byte; anything else is lost.
            if (bus.i_rx_valid && !(state inside {IDLE, ASSEMBLE}))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    // A byte beats a simultaneous start.
                    if (bus.i_rx_valid) begin
                        partial[7:0] <= bus.i_rx_byte;
                        byte_idx     <= 2'd1;
                        busy         <= 1'b1;
                        state        <= ASSEMBLE;
                    end else if (i_start && loaded_count != '0) begin
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                ASSEMBLE: begin
                    if (bus.i_rx_valid) begin
                        if (byte_idx == 2'd3) begin
                            load_instruction <= {bus.i_rx_byte, partial};
                            write_enable     <= 1'b1;
                            byte_idx         <= 2'd0;
                            cnt              <= '0;
                            state            <= WRITE_HI;
                        end else begin
                            partial[{byte_idx, 3'b000} +: 8] <= bus.i_rx_byte;
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE_HI: begin
                    if (cnt == WE_HIGH_LAST) begin
                        write_enable <= 1'b0;
                        cnt          <= '0;
                        state        <= WRITE_LO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE_LO: begin
                    if (cnt == WE_LOW_LAST) begin
                        cnt          <= '0;
                        load_address <= load_address + ADDR_W'(1);
                        loaded_count <= loaded_count + (ADDR_W+1)'(1);
                        if (loaded_count == LAST_BEFORE_FULL) begin
                            state <= FULL;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FULL: begin
                    if (i_start)
                        state <= RUN;
                end
                RUN: begin
                    if (bus.i_data_ready && bus.i_id_ack) begin
                        flush <= 1'b1;
                        cnt   <= '0;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        flush   <= 1'b0;
                        retired <= retired + (ADDR_W+1)'(1);
                        state   <= WAIT_CLR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_CLR: begin
                    // Hold off the next flush until IF/ID has actually emptied.
                    if (!bus.i_data_ready) begin
                        if (retired == loaded_count) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (i_clear) begin
                        retired      <= '0;
                        loaded_count <= '0;
                        load_address <= '0;
                        overrun      <= 1'b0;
                        done         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_load_run_controller.sv
// tb/tb_imem_load_run_controller.sv - directed self-checking bench for imem_load_run_controller
module tb_imem_load_run_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_clear = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_overrun;
    logic [3:0] o_loaded_count;

    int tests  = 0;
    int failed = 0;

    imem_load_run_controller_if #(.ADDR_W(3)) bus ();

    imem_load_run_controller #(
        .DEPTH(8), .ADDR_W(3), .WE_HIGH(2), .WE_LOW(4), .FLUSH_LEN(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .i_start        (i_start),
        .i_clear        (i_clear),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overrun      (o_overrun),
        .o_loaded_count (o_loaded_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_byte  = b;
        step();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++)
            send_byte(tmp[8*k +: 8]);
    endtask

    // Called right after the 4th byte edge: checks the write pulse shape and stability.
    task automatic check_write(input string tag, input logic [31:0] w, input logic [2:0] a);
        int   hi = 0;
        int   lo = 0;
        int   guard = 0;
        logic stable = 1'b1;
        logic [3:0] start_cnt;
        start_cnt = o_loaded_count;
        check($sformatf("%s_we_rise", tag), bus.o_write_enable, 1'b1);
        check($sformatf("%s_addr", tag), bus.o_load_address, a);
        check($sformatf("%s_instr", tag), bus.o_load_instruction, w);
        while (bus.o_write_enable && guard < 20) begin
            if (bus.o_load_address !== a || bus.o_load_instruction !== w) stable = 1'b0;
            hi++; guard++; step();
        end
        while (!bus.o_write_enable && o_loaded_count == start_cnt && guard < 20) begin
            if (bus.o_load_address !== a || bus.o_load_instruction !== w) stable = 1'b0;
            lo++; guard++; step();
        end
        check($sformatf("%s_we_high_cycles", tag), hi, 2);
        check($sformatf("%s_we_low_cycles", tag), lo, 4);
        check($sformatf("%s_stable", tag), stable, 1'b1);
        check($sformatf("%s_count", tag), o_loaded_count, start_cnt + 4'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Retire one instruction: ack with data_ready high, then hold data_ready to prove no re-flush.
    task automatic retire(input int idx);
        logic seen = 1'b0;
        bus.i_data_ready = 1'b1;
        step();
        bus.i_id_ack = 1'b1;
        step();
        bus.i_id_ack = 1'b0;
        check($sformatf("retire%0d_flush_rise", idx), bus.o_flush, 1'b1);
        step();
        check($sformatf("retire%0d_flush_fall", idx), bus.o_flush, 1'b0);
        bus.i_id_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.o_flush) seen = 1'b1;
        end
        bus.i_id_ack = 1'b0;
        check($sformatf("retire%0d_no_reflush", idx), seen, 1'b0);
        bus.i_data_ready = 1'b0;
        step();
    endtask

    initial begin
        logic seen;
        bus.i_rx_valid   = 1'b0;
        bus.i_rx_byte    = 8'h00;
        bus.i_data_ready = 1'b0;
        bus.i_id_ack     = 1'b0;
        #1;
        check("rst_we", bus.o_write_enable, 1'b0);
        check("rst_flush", bus.o_flush, 1'b0);
        check("rst_addr", bus.o_load_address, 3'd0);
        check("rst_instr", bus.o_load_instruction, 32'h0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        check("rst_count", o_loaded_count, 4'd0);
        step();
        rst = 1'b1;
        step();

        // First word, little-endian packing.
        send_word(32'h0050_0013);
        check_write("w0", 32'h0050_0013, 3'd0);
        check("w0_idle_busy", o_busy, 1'b0);

        // Fill to DEPTH, then one byte too many.
        for (int k = 1; k < 8; k++) begin
            send_word(32'h1111_0000 + 32'(k));
            check_write($sformatf("w%0d", k), 32'h1111_0000 + 32'(k), 3'(k));
        end
        check("full_busy", o_busy, 1'b1);
        check("full_count", o_loaded_count, 4'd8);
        check("full_addr_wrap", bus.o_load_address, 3'd0);
        check("full_overrun_before", o_overrun, 1'b0);
        send_byte(8'h99);
        check("full_overrun", o_overrun, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.o_write_enable) seen = 1'b1;
        end
        check("full_no_9th_write", seen, 1'b0);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("full_clear_ignored_count", o_loaded_count, 4'd8);
        check("full_clear_ignored_ovr", o_overrun, 1'b1);

        do_reset();
        check("reset2_count", o_loaded_count, 4'd0);

        // Start with nothing loaded is ignored; byte beats start.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("start_empty_busy", o_busy, 1'b0);
        i_start = 1'b1;
        send_byte(8'h11);
        i_start = 1'b0;
        check("byte_wins_busy", o_busy, 1'b1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check_write("r0", 32'h4433_2211, 3'd0);
        send_word(32'hDEAD_BEEF);
        check_write("r1", 32'hDEAD_BEEF, 3'd1);
        send_word(32'h0000_0073);
        check_write("r2", 32'h0000_0073, 3'd2);

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("run_busy", o_busy, 1'b1);
        check("run_done", o_done, 1'b0);

        // Ack without data_ready is ignored.
        bus.i_id_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.o_flush) seen = 1'b1;
        end
        bus.i_id_ack = 1'b0;
        check("ack_no_ready_flush", seen, 1'b0);

        // data_ready without ack for 20 cycles: no flush, then 1-cycle latency.
        bus.i_data_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.o_flush) seen = 1'b1;
        end
        check("ready_no_ack_flush", seen, 1'b0);
        bus.i_id_ack = 1'b1;
        step();
        bus.i_id_ack = 1'b0;
        check("flush1_latency", bus.o_flush, 1'b1);
        step();
        check("flush1_width", bus.o_flush, 1'b0);
        bus.i_data_ready = 1'b0;
        step();
        check("after1_done", o_done, 1'b0);

        retire(2);
        check("after2_done", o_done, 1'b0);
        check("after2_busy", o_busy, 1'b1);
        retire(3);
        check("after3_done", o_done, 1'b1);
        check("after3_busy", o_busy, 1'b0);

        send_byte(8'h55);
        check("done_overrun", o_overrun, 1'b1);
        check("done_held", o_done, 1'b1);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clear_done", o_done, 1'b0);
        check("clear_count", o_loaded_count, 4'd0);
        check("clear_overrun", o_overrun, 1'b0);
        check("clear_busy", o_busy, 1'b0);

        // Reset in the middle of a write pulse.
        send_word(32'hA5A5_0001);
        check_write("p0", 32'hA5A5_0001, 3'd0);
        send_word(32'hA5A5_0002);
        check("mid_we_high", bus.o_write_enable, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_we", bus.o_write_enable, 1'b0);
        check("mid_rst_count", o_loaded_count, 4'd0);
        step();
        rst = 1'b1;
        step();
        send_word(32'hCAFE_F00D);
        check_write("post_rst", 32'hCAFE_F00D, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/imem_load_run_controller.md
Name: imem_load_run_controller

Overview:
- Sequencer in front of the instruction fetch stage. It collects a UART byte stream into 32-bit instructions and writes them into the fetch stage's 8-entry program memory through its write port (write enable, 3-bit load address, 32-bit load instruction).
- On a start command it drives the fetch-stage flush handshake, retiring each fetched instruction once the decoder acknowledges it, and signals completion when every loaded instruction has been retired.
- Sits between the UART receiver, the decode stage and the fetch stage.

Parameters:
- DEPTH, 8, program memory words; loaded count saturates here.
- ADDR_W, 3, load address width, log2(DEPTH).
- WE_HIGH, 2, cycles o_write_enable is held high per word.
- WE_LOW, 4, cycles of low gap after each write; address and data stay stable throughout.
- FLUSH_LEN, 1, cycles o_flush is held high per retired instruction.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_rx_valid  in  1  one-cycle strobe: i_rx_byte valid.
- i_rx_byte  in  8  received byte.
- i_start  in  1  level/pulse: begin run.
- i_clear  in  1  pulse: leave DONE and clear counts.
- i_data_ready  in  1  fetch stage IF/ID register occupied.
- i_id_ack  in  1  decoder has consumed the current instruction.
- o_write_enable  out  1  program memory write enable to fetch stage.
- o_load_address  out  ADDR_W  program memory write address.
- o_load_instruction  out  32  program memory write data.
- o_flush  out  1  flush to fetch stage.
- o_busy  out  1  high in any state except IDLE and DONE.
- o_done  out  1  high in DONE.
- o_overrun  out  1  sticky: a byte was dropped.
- o_loaded_count  out  ADDR_W+1  words written, 0..DEPTH.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - Byte index, address, loaded and retired counters go to 0.
  - All outputs go to 0.
- States: IDLE, ASSEMBLE, WRITE_HI, WRITE_LO, FULL, RUN, FLUSH, WAIT_CLR, DONE.
- Byte packing is little-endian: byte k (k=0..3) lands in bits [8k+7:8k].
- IDLE:
  - i_rx_valid: store byte 0, go to ASSEMBLE.
  - i_start with loaded_count>0 and no i_rx_valid: go to RUN.
  - i_start with loaded_count=0: ignored.
  - i_rx_valid and i_start in the same cycle: the byte wins and i_start is ignored.
- ASSEMBLE:
  - Each i_rx_valid stores the next byte.
  - On the 4th byte, o_load_instruction updates on the same edge and the state goes to WRITE_HI.
  - i_start is ignored.
- WRITE_HI: o_write_enable=1 for exactly WE_HIGH cycles, then go to WRITE_LO.
- WRITE_LO:
  - o_write_enable=0 for WE_LOW cycles.
  - On exit: address +1 (wraps mod DEPTH), loaded_count +1.
  - Next state is FULL if loaded_count reaches DEPTH, else IDLE.
- o_load_address and o_load_instruction are constant from WRITE_HI entry through WRITE_LO exit.
- i_rx_valid in WRITE_HI, WRITE_LO, FULL, RUN, FLUSH, WAIT_CLR or DONE: byte dropped, o_overrun set to 1. o_overrun clears only on reset or i_clear.
- FULL: i_start goes to RUN; bytes are dropped.
- RUN: when i_data_ready=1 and i_id_ack=1 in the same cycle, go to FLUSH. i_id_ack without i_data_ready is ignored.
- FLUSH: o_flush=1 for FLUSH_LEN cycles, retired +1, then go to WAIT_CLR.
- WAIT_CLR:
  - Wait for i_data_ready=0.
  - If retired==loaded_count, go to DONE; else go to RUN.
  - A new flush is never issued before i_data_ready has returned low.
- DONE:
  - o_done=1.
  - i_clear: counters, address and o_overrun go to 0; state goes to IDLE.
  - i_clear in any other state is ignored.
- Latency:
  - 4th byte strobe to o_write_enable rising: 1 cycle.
  - i_data_ready&i_id_ack to o_flush rising: 1 cycle.
- Reset mid-write or mid-flush: o_write_enable and o_flush drop immediately (async); partial words are discarded.

Test Plan:
- Reset, then bytes 0x13,0x00,0x50,0x00 -> o_load_instruction=0x00500013, o_load_address=0, o_write_enable high for 2 cycles then low for 4, o_loaded_count=1, state IDLE.
- Load 8 words (32 bytes), then send a 33rd byte -> addresses 0..7 written in order, o_loaded_count=8, o_overrun=1, FULL held, no 9th write.
- 3 words loaded, i_start; model i_data_ready high with i_id_ack pulses -> exactly 3 one-cycle o_flush pulses, each after i_data_ready falls from the prior flush, then o_done=1.
- In RUN, hold i_data_ready=1 and i_id_ack=0 for 20 cycles -> no o_flush; i_id_ack=1 -> o_flush exactly 1 cycle later.
- i_start with o_loaded_count=0 -> stays IDLE, o_busy=0. Same-cycle i_rx_valid+i_start in IDLE -> byte stored, state ASSEMBLE.
- Assert rst low during WRITE_HI -> o_write_enable=0 at once; after release, o_loaded_count=0 and the next 4 bytes write to address 0.
